// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped cache controller sequencing hit check,
// dirty writeback, RAM fill and final cache access for a CPU port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpuReq/We/Flush   CPU request, store select, whole-cache clear
//   cpuAddr/DataIn    CPU address and store data (latched on accept)
//   cpuDataOut/Ready  load result and one-cycle completion pulse
//   busy              high while a request is in flight
//   cacheCntrl/Addr/DataIn  cache command port (00 CLR 01 STATUS
//                           10 READ 11 WRITE)
//   cacheDataOut, isHit, isClean, victimData, victimAddr  cache results
//   ramAddr/DataOut/Re/We, ramDataIn, ramAck  RAM handshake
//   hitCount, missCount  only with CACHE_CTRL_STATS_EN defined
module dm_cache_ctrl #(
  parameter int ramWidth      = 8,
  parameter int addrWidth     = 8,
  parameter int blockAddrBits = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpuReq,
  input  logic                 cpuWe,
  input  logic                 cpuFlush,
  input  logic [addrWidth-1:0] cpuAddr,
  input  logic [ramWidth-1:0]  cpuDataIn,
  output logic [ramWidth-1:0]  cpuDataOut,
  output logic                 cpuReady,
  output logic                 busy,
  output logic [1:0]           cacheCntrl,
  output logic [ramWidth-1:0]  cacheAddr,
  output logic [ramWidth-1:0]  cacheDataIn,
  input  logic [ramWidth-1:0]  cacheDataOut,
  input  logic                 isHit,
  input  logic                 isClean,
  input  logic [ramWidth-1:0]  victimData,
  input  logic [addrWidth-1:0] victimAddr,
  output logic [addrWidth-1:0] ramAddr,
  output logic [ramWidth-1:0]  ramDataOut,
  output logic                 ramRe,
  output logic                 ramWe,
  input  logic [ramWidth-1:0]  ramDataIn,
  input  logic                 ramAck
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]          hitCount,
  output logic [15:0]          missCount
`endif
);

  if (addrWidth != ramWidth ||
      blockAddrBits >= addrWidth) begin : g_bad_cfg
    $error("dm_cache_ctrl: bad parameters");
  end

  typedef enum logic [2:0] {
    IDLE, FLUSH, CHECK, WB,
    FILL, FILLWR, ACCESS, DONE
  } state_e;

  localparam logic [1:0] CMD_CLR    = 2'b00;
  localparam logic [1:0] CMD_STATUS = 2'b01;
  localparam logic [1:0] CMD_READ   = 2'b10;
  localparam logic [1:0] CMD_WRITE  = 2'b11;

  state_e               state_q, state_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [ramWidth-1:0]  wdata_q, wdata_d;
  logic                 flushPh_q, flushPh_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [ramWidth-1:0]  cdin_q, cdin_d;
  logic [ramWidth-1:0]  dout_q, dout_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 ramRe_q, ramRe_d;
  logic                 ramWe_q, ramWe_d;
  logic [addrWidth-1:0] ramAddr_q, ramAddr_d;
  logic [ramWidth-1:0]  ramDout_q, ramDout_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    flushPh_d = 1'b0;
    cmd_d     = CMD_READ;
    cdin_d    = cdin_q;
    dout_d    = dout_q;
    ready_d   = 1'b0;
    ramRe_d   = 1'b0;
    ramWe_d   = 1'b0;
    ramAddr_d = ramAddr_q;
    ramDout_d = ramDout_q;

    unique case (state_q)
      IDLE: begin
        if (cpuFlush) begin
          state_d = FLUSH;
        end else if (cpuReq) begin
          addr_d  = cpuAddr;
          we_d    = cpuWe;
          wdata_d = cpuDataIn;
          state_d = CHECK;
        end
      end
      // CLR cycle, then one settle cycle so the
      // clear has landed before completion.
      FLUSH: begin
        if (!flushPh_q) flushPh_d = 1'b1;
        else            state_d   = DONE;
      end
      CHECK: begin
        if (isHit) begin
          state_d = ACCESS;
        end else if (!isClean) begin
          state_d   = WB;
          ramAddr_d = victimAddr;
          ramDout_d = victimData;
        end else if (!we_q) begin
          state_d   = FILL;
          ramAddr_d = addr_q;
        end else begin
          state_d = ACCESS;
        end
      end
      WB: begin
        if (ramAck) begin
          if (we_q) begin
            state_d = ACCESS;
          end else begin
            state_d   = FILL;
            ramAddr_d = addr_q;
          end
        end
      end
      FILL: begin
        if (ramAck) begin
          cdin_d  = ramDataIn;
          state_d = FILLWR;
        end
      end
      FILLWR: state_d = ACCESS;
      ACCESS: begin
        if (!we_q) dout_d = cacheDataOut;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode the state being entered.
    unique case (state_d)
      FLUSH:  cmd_d   = flushPh_d ? CMD_READ : CMD_CLR;
      CHECK:  cmd_d   = CMD_STATUS;
      WB:     ramWe_d = 1'b1;
      FILL:   ramRe_d = 1'b1;
      FILLWR: cmd_d   = CMD_WRITE;
      ACCESS: begin
        if (we_q) begin
          cmd_d  = CMD_WRITE;
          cdin_d = wdata_q;
        end
      end
      DONE:   ready_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      flushPh_q <= 1'b0;
      cmd_q     <= CMD_READ;
      cdin_q    <= '0;
      dout_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      ramRe_q   <= 1'b0;
      ramWe_q   <= 1'b0;
      ramAddr_q <= '0;
      ramDout_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      flushPh_q <= flushPh_d;
      cmd_q     <= cmd_d;
      cdin_q    <= cdin_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      ramRe_q   <= ramRe_d;
      ramWe_q   <= ramWe_d;
      ramAddr_q <= ramAddr_d;
      ramDout_q <= ramDout_d;
    end
  end

  assign cpuDataOut  = dout_q;
  assign cpuReady    = ready_q;
  assign busy        = busy_q;
  assign cacheCntrl  = cmd_q;
  assign cacheAddr   = addr_q;
  assign cacheDataIn = cdin_q;
  assign ramAddr     = ramAddr_q;
  assign ramDataOut  = ramDout_q;
  assign ramRe       = ramRe_q;
  assign ramWe       = ramWe_q;

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == FLUSH && state_d == DONE)) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == CHECK) begin
      if (isHit && hit_q != 16'hFFFF)
        hit_q <= hit_q + 16'd1;
      if (!isHit && miss_q != 16'hFFFF)
        miss_q <= miss_q + 16'd1;
    end
  end

  assign hitCount  = hit_q;
  assign missCount = miss_q;
`endif

endmodule
